// File: rtl/riscv_pkg.sv
// Shared RV32I field encodings and immediate limits
// for the instruction assembler path.
package riscv_pkg;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_R = 2'b11
  } imm_src_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;

  localparam int IS_MIN = -2048;
  localparam int IS_MAX = 2047;
  localparam int B_MIN  = -4096;
  localparam int B_MAX  = 4094;

  function automatic logic in_range(
    input logic [31:0] v,
    input int          lo,
    input int          hi
  );
    return ($signed(v) >= lo) && ($signed(v) <= hi);
  endfunction

endpackage

// File: rtl/instr_assembler_imm_pack.sv
// Combinational RV32I field packer with
// immediate range / alignment checking.
module imm_pack
  import riscv_pkg::*;
(
  input  imm_src_e    imm_src_i,
  input  logic [6:0]  op_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [31:0] imm_i,
  output logic [31:0] word_o,
  output logic        err_o
);

  always_comb begin
    word_o = '0;
    err_o  = 1'b0;
    unique case (imm_src_i)
      IMM_I: begin
        word_o = {imm_i[11:0], rs1_i, funct3_i,
                  rd_i, op_i};
        err_o  = !in_range(imm_i, IS_MIN, IS_MAX);
      end
      IMM_S: begin
        word_o = {imm_i[11:5], rs2_i, rs1_i,
                  funct3_i, imm_i[4:0], op_i};
        err_o  = !in_range(imm_i, IS_MIN, IS_MAX);
      end
      IMM_B: begin
        word_o = {imm_i[12], imm_i[10:5], rs2_i,
                  rs1_i, funct3_i, imm_i[4:1],
                  imm_i[11], op_i};
        // branch offsets must also be halfword aligned
        err_o  = !in_range(imm_i, B_MIN, B_MAX)
                 || imm_i[0];
      end
      IMM_R: begin
        word_o = {funct7_i, rs2_i, rs1_i, funct3_i,
                  rd_i, op_i};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/instr_assembler.sv
// Registered RV32I instruction assembler with
// address tagging, word count and sticky error.
module instr_assembler
  import riscv_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              restart,
  input  logic              clr_err,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        ImmSrc,
  input  logic [6:0]        Op,
  input  logic [2:0]        Funct3,
  input  logic [6:0]        Funct7,
  input  logic [4:0]        Rd,
  input  logic [4:0]        Rs1,
  input  logic [4:0]        Rs2,
  input  logic [31:0]       Imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       InstrOut,
  output logic [ADDR_W-1:0] InstrAddr,
  output logic              ImmErr,
  output logic              ErrSticky,
  output logic [15:0]       WordCount
);

  logic [31:0]       word;
  logic              err;
  logic              acc;
  logic [ADDR_W-1:0] start;

  logic              vld_q, vld_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_q, err_d;
  logic              stk_q, stk_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [15:0]       wc_q, wc_d;

  imm_pack u_pack (
    .imm_src_i (imm_src_e'(ImmSrc)),
    .op_i      (Op),
    .funct3_i  (Funct3),
    .funct7_i  (Funct7),
    .rd_i      (Rd),
    .rs1_i     (Rs1),
    .rs2_i     (Rs2),
    .imm_i     (Imm),
    .word_o    (word),
    .err_o     (err)
  );

  assign in_ready = !vld_q || out_ready;
  assign acc      = in_valid && in_ready;
  // restart takes effect for a word accepted alongside it
  assign start    = restart ? BASE_ADDR : cnt_q;

  always_comb begin
    vld_d   = vld_q;
    instr_d = instr_q;
    addr_d  = addr_q;
    err_d   = err_q;
    stk_d   = stk_q;
    cnt_d   = cnt_q;
    wc_d    = wc_q;
    if (acc) begin
      vld_d   = 1'b1;
      instr_d = word;
      addr_d  = start;
      err_d   = err;
      cnt_d   = start + ADDR_W'(4);
    end else begin
      if (out_ready) vld_d = 1'b0;
      if (restart)   cnt_d = BASE_ADDR;
    end
    if (restart)
      wc_d = acc ? 16'd1 : 16'd0;
    else if (acc && wc_q != 16'hFFFF)
      wc_d = wc_q + 16'd1;
    if (acc && err)   stk_d = 1'b1;
    else if (clr_err) stk_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q   <= 1'b0;
      instr_q <= '0;
      addr_q  <= BASE_ADDR;
      err_q   <= 1'b0;
      stk_q   <= 1'b0;
      cnt_q   <= BASE_ADDR;
      wc_q    <= '0;
    end else begin
      vld_q   <= vld_d;
      instr_q <= instr_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
      stk_q   <= stk_d;
      cnt_q   <= cnt_d;
      wc_q    <= wc_d;
    end
  end

  assign out_valid = vld_q;
  assign InstrOut  = instr_q;
  assign InstrAddr = addr_q;
  assign ImmErr    = err_q;
  assign ErrSticky = stk_q;
  assign WordCount = wc_q;

endmodule

// File: tb/tb_instr_assembler.sv
// Self-checking bench for instr_assembler:
// directed encodings, handshake, restart, random round-trip.
module tb_instr_assembler;

  logic        clk = 1'b0;
  logic        reset, restart, clr_err;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [1:0]  ImmSrc;
  logic [6:0]  Op, Funct7;
  logic [2:0]  Funct3;
  logic [4:0]  Rd, Rs1, Rs2;
  logic [31:0] Imm, InstrOut, InstrAddr;
  logic        ImmErr, ErrSticky;
  logic [15:0] WordCount;

  logic        s_in_valid, s_in_ready, s_out_valid;
  logic        s_out_ready, s_err, s_sticky;
  logic [31:0] s_instr;
  logic [3:0]  s_addr;
  logic [15:0] s_wc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_assembler dut (
    .clk(clk), .reset(reset), .restart(restart),
    .clr_err(clr_err), .in_valid(in_valid),
    .in_ready(in_ready), .ImmSrc(ImmSrc), .Op(Op),
    .Funct3(Funct3), .Funct7(Funct7), .Rd(Rd),
    .Rs1(Rs1), .Rs2(Rs2), .Imm(Imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .InstrOut(InstrOut), .InstrAddr(InstrAddr),
    .ImmErr(ImmErr), .ErrSticky(ErrSticky),
    .WordCount(WordCount)
  );

  instr_assembler #(.ADDR_W(4), .BASE_ADDR(4'h0))
  u_small (
    .clk(clk), .reset(reset), .restart(1'b0),
    .clr_err(1'b0), .in_valid(s_in_valid),
    .in_ready(s_in_ready), .ImmSrc(ImmSrc), .Op(Op),
    .Funct3(Funct3), .Funct7(Funct7), .Rd(Rd),
    .Rs1(Rs1), .Rs2(Rs2), .Imm(Imm),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .InstrOut(s_instr), .InstrAddr(s_addr),
    .ImmErr(s_err), .ErrSticky(s_sticky),
    .WordCount(s_wc)
  );

  // reference encoder built from the RV32I field layouts
  function automatic logic [31:0] ref_enc(
    input logic [1:0] s, input logic [6:0] op,
    input logic [2:0] f3, input logic [6:0] f7,
    input logic [4:0] rd, input logic [4:0] r1,
    input logic [4:0] r2, input logic [31:0] im);
    case (s)
      2'b00: return {im[11:0], r1, f3, rd, op};
      2'b01: return {im[11:5], r2, r1, f3, im[4:0], op};
      2'b10: return {im[12], im[10:5], r2, r1, f3,
                     im[4:1], im[11], op};
      default: return {f7, r2, r1, f3, rd, op};
    endcase
  endfunction

  function automatic logic ref_err(
    input logic [1:0] s, input logic [31:0] im);
    int v;
    v = $signed(im);
    case (s)
      2'b00, 2'b01: return (v < -2048) || (v > 2047);
      2'b10: return (v < -4096) || (v > 4094)
                    || (v % 2 != 0);
      default: return 1'b0;
    endcase
  endfunction

  // immediate extender applied to InstrOut[31:7]
  function automatic logic [31:0] ext(
    input logic [24:0] w, input logic [1:0] s);
    case (s)
      2'b00: return {{20{w[24]}}, w[24:13]};
      2'b01: return {{20{w[24]}}, w[24:18], w[4:0]};
      2'b10: return {{19{w[24]}}, w[24], w[0],
                     w[23:18], w[4:1], 1'b0};
      default: return 32'h0;
    endcase
  endfunction

  task automatic set_f(
    input logic [1:0] s, input logic [6:0] op,
    input logic [2:0] f3, input logic [4:0] rd,
    input logic [4:0] r1, input logic [4:0] r2,
    input logic [31:0] im);
    ImmSrc = s; Op = op; Funct3 = f3; Funct7 = 7'h20;
    Rd = rd; Rs1 = r1; Rs2 = r2; Imm = im;
  endtask

  task automatic do_reset();
    reset = 1'b1; restart = 1'b0; clr_err = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1;
    s_in_valid = 1'b0; s_out_ready = 1'b1;
    set_f(2'b00, 7'h03, 3'd2, 5'd5, 5'd2, 5'd0, -4);
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (out_valid !== 1'b0 || InstrOut !== 32'h0 ||
        InstrAddr !== 32'h0 || ImmErr !== 1'b0 ||
        ErrSticky !== 1'b0 || WordCount !== 16'h0 ||
        in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset: v=%b i=%h a=%h e=%b s=%b wc=%0d r=%b want 0/0/0/0/0/0/1",
               out_valid, InstrOut, InstrAddr, ImmErr,
               ErrSticky, WordCount, in_ready);
    end
  endtask

  task automatic test_encode();
    logic [1:0]  src [5];
    logic [6:0]  op  [5];
    logic [2:0]  f3  [5];
    logic [4:0]  rd  [5];
    logic [4:0]  r1  [5];
    logic [4:0]  r2  [5];
    logic [31:0] im  [5];
    logic [31:0] ex  [5];
    logic        ee  [5];
    logic        es  [5];
    src = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b00};
    op  = '{7'h03, 7'h23, 7'h63, 7'h63, 7'h03};
    f3  = '{3'd2, 3'd2, 3'd0, 3'd0, 3'd2};
    rd  = '{5'd5, 5'd0, 5'd0, 5'd0, 5'd5};
    r1  = '{5'd2, 5'd2, 5'd1, 5'd1, 5'd2};
    r2  = '{5'd0, 5'd6, 5'd2, 5'd2, 5'd0};
    im  = '{-4, 8, 8, 7, 2048};
    ex  = '{32'hFFC12283, 32'h00612423, 32'h00208463,
            32'h00208363, 32'h80012283};
    ee  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    es  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_f(src[i], op[i], f3[i], rd[i], r1[i],
            r2[i], im[i]);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || InstrOut !== ex[i] ||
          InstrAddr !== 32'(i * 4) ||
          ImmErr !== ee[i] || ErrSticky !== es[i] ||
          WordCount !== 16'(i + 1)) begin
        errors++;
        $display("FAIL encode[%0d]: v=%b i=%h a=%h e=%b s=%b wc=%0d want 1 %h %h %b %b %0d",
                 i, out_valid, InstrOut, InstrAddr,
                 ImmErr, ErrSticky, WordCount, ex[i],
                 32'(i * 4), ee[i], es[i], i + 1);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_clr_err();
    do_reset();
    set_f(2'b10, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, 7);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    clr_err = 1'b1;
    @(negedge clk);
    checks++;
    if (ErrSticky !== 1'b0) begin
      errors++;
      $display("FAIL clr_err: sticky=%b want 0",
               ErrSticky);
    end
    in_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (ErrSticky !== 1'b1 || ImmErr !== 1'b1) begin
      errors++;
      $display("FAIL clr_set_wins: sticky=%b err=%b want 1 1",
               ErrSticky, ImmErr);
    end
    set_f(2'b10, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, 8);
    @(negedge clk);
    in_valid = 1'b0;
    clr_err = 1'b0;
    checks++;
    if (ErrSticky !== 1'b0 || ImmErr !== 1'b0) begin
      errors++;
      $display("FAIL clr_legal: sticky=%b err=%b want 0 0",
               ErrSticky, ImmErr);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    set_f(2'b01, 7'h23, 3'd2, 5'd0, 5'd2, 5'd6, 8);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 ||
          InstrOut !== 32'hFFC12283 ||
          InstrAddr !== 32'h0 || WordCount !== 16'd1) begin
        errors++;
        $display("FAIL stall[%0d]: r=%b v=%b i=%h a=%h wc=%0d want 0 1 ffc12283 0 1",
                 i, in_ready, out_valid, InstrOut,
                 InstrAddr, WordCount);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL release_ready: r=%b want 1",
               in_ready);
    end
    @(negedge clk);
    checks++;
    if (InstrOut !== 32'h00612423 ||
        InstrAddr !== 32'h4 || WordCount !== 16'd2) begin
      errors++;
      $display("FAIL b2b_first: i=%h a=%h wc=%0d want 00612423 4 2",
               InstrOut, InstrAddr, WordCount);
    end
    set_f(2'b10, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, 8);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (InstrOut !== 32'h00208463 ||
        InstrAddr !== 32'h8 || WordCount !== 16'd3) begin
      errors++;
      $display("FAIL b2b_second: i=%h a=%h wc=%0d want 00208463 8 3",
               InstrOut, InstrAddr, WordCount);
    end
  endtask

  task automatic test_restart();
    do_reset();
    in_valid = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (InstrAddr !== 32'd16 || WordCount !== 16'd5) begin
      errors++;
      $display("FAIL five_words: a=%h wc=%0d want 10 5",
               InstrAddr, WordCount);
    end
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    checks++;
    if (InstrAddr !== 32'd0 || WordCount !== 16'd1) begin
      errors++;
      $display("FAIL restart_acc: a=%h wc=%0d want 0 1",
               InstrAddr, WordCount);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (InstrAddr !== 32'd4 || WordCount !== 16'd2) begin
      errors++;
      $display("FAIL after_restart: a=%h wc=%0d want 4 2",
               InstrAddr, WordCount);
    end
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || InstrAddr !== 32'd8 ||
        WordCount !== 16'd0) begin
      errors++;
      $display("FAIL held_restart: v=%b a=%h wc=%0d want 1 8 0",
               out_valid, InstrAddr, WordCount);
    end
    out_ready = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (InstrAddr !== 32'd0 || WordCount !== 16'd1) begin
      errors++;
      $display("FAIL restart_idle: a=%h wc=%0d want 0 1",
               InstrAddr, WordCount);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || WordCount !== 16'd0 ||
        InstrOut !== 32'h0 || InstrAddr !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid: v=%b wc=%0d i=%h a=%h want 0 0 0 0",
               out_valid, WordCount, InstrOut, InstrAddr);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    s_in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (s_out_valid !== 1'b1 ||
          s_addr !== 4'(i * 4) || s_err !== 1'b0 ||
          s_sticky !== 1'b0 || s_in_ready !== 1'b1 ||
          s_wc !== 16'(i + 1) ||
          s_instr !== 32'hFFC12283) begin
        errors++;
        $display("FAIL wrap[%0d]: v=%b a=%h wc=%0d i=%h want 1 %h %0d ffc12283",
                 i, s_out_valid, s_addr, s_wc, s_instr,
                 4'(i * 4), i + 1);
      end
    end
    s_in_valid = 1'b0;
  endtask

  function automatic logic [31:0] rnd_imm(
    input logic [1:0] s);
    int v;
    case ($urandom_range(0, 7))
      0: return $urandom();
      1: begin
        v = (s == 2'b10) ? 4095 : 2048;
        return ($urandom_range(0, 1) == 1) ? v : -v - 1;
      end
      2: return (s == 2'b10) ? 4094 : 2047;
      3: return (s == 2'b10) ? -4096 : -2048;
      default: begin
        v = int'($urandom_range(0, 4095)) - 2048;
        return (s == 2'b10) ? v * 2 : v;
      end
    endcase
  endfunction

  task automatic test_random();
    logic        m_vld = 1'b0, m_err = 1'b0;
    logic        m_stk = 1'b0, m_new = 1'b0;
    logic [31:0] m_word = '0, m_addr = '0;
    logic [31:0] m_cnt = '0, m_imm = '0;
    logic [1:0]  m_src = '0;
    logic [15:0] m_wc = '0;
    logic        acc;
    int          words = 0, cyc = 0;
    do_reset();
    while (words < 1000 && cyc < 20000) begin
      cyc++;
      checks++;
      if (out_valid !== m_vld ||
          (m_vld && (InstrOut !== m_word ||
                     InstrAddr !== m_addr ||
                     ImmErr !== m_err)) ||
          WordCount !== m_wc || ErrSticky !== m_stk) begin
        errors++;
        $display("FAIL rand cyc%0d: v=%b i=%h a=%h e=%b wc=%0d s=%b want %b %h %h %b %0d %b",
                 cyc, out_valid, InstrOut, InstrAddr,
                 ImmErr, WordCount, ErrSticky, m_vld,
                 m_word, m_addr, m_err, m_wc, m_stk);
      end
      if (m_new && !m_err && m_src != 2'b11) begin
        checks++;
        if (ext(InstrOut[31:7], m_src) !== m_imm) begin
          errors++;
          $display("FAIL roundtrip cyc%0d: ext=%h want %h",
                   cyc, ext(InstrOut[31:7], m_src),
                   m_imm);
        end
      end
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      ImmSrc = 2'($urandom_range(0, 3));
      Op = 7'($urandom()); Funct3 = 3'($urandom());
      Funct7 = 7'($urandom()); Rd = 5'($urandom());
      Rs1 = 5'($urandom()); Rs2 = 5'($urandom());
      Imm = rnd_imm(ImmSrc);
      #1;
      checks++;
      if (in_ready !== (!m_vld || out_ready)) begin
        errors++;
        $display("FAIL rand_ready cyc%0d: r=%b want %b",
                 cyc, in_ready, !m_vld || out_ready);
      end
      acc = in_valid && (!m_vld || out_ready);
      m_new = acc;
      if (acc) begin
        m_vld = 1'b1;
        m_word = ref_enc(ImmSrc, Op, Funct3, Funct7,
                         Rd, Rs1, Rs2, Imm);
        m_err = ref_err(ImmSrc, Imm);
        m_addr = m_cnt;
        m_cnt = m_cnt + 4;
        m_imm = Imm;
        m_src = ImmSrc;
        if (m_wc != 16'hFFFF) m_wc = m_wc + 1;
        if (m_err) m_stk = 1'b1;
        words++;
      end else if (out_ready) begin
        m_vld = 1'b0;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++;
    if (words < 1000) begin
      errors++;
      $display("FAIL rand_budget: words=%0d want 1000",
               words);
    end
  endtask

  initial begin
    test_reset();
    test_encode();
    test_clr_err();
    test_backpressure();
    test_restart();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
